// File: rtl/line_clear.sv
// Line-clear engine: scans the board bottom-up, shifts rows above each full row down, clears the top row.
// Optional LINE_CLEAR_COUNT_EN enables the saturating lines_cleared counter; otherwise it reads constant 0.
module line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] ram_Q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared,
  output logic [2:0] o_dbg_state
);

  localparam int XW = $clog2(COLS + 1);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [XW-1:0] X_END  = XW'(COLS);
  localparam logic [YW-1:0] Y_BOT  = YW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    COPY_RD = 3'd2,
    COPY_WR = 3'd3,
    CLR_TOP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          r_state, w_state_n;
  logic [YW-1:0]   r_y, w_y_n;
  logic [YW-1:0]   r_r, w_r_n;
  logic [XW-1:0]   r_x, w_x_n;
  logic            r_full, w_full_n;
  logic            w_occ;

  function automatic logic [7:0] cell_addr(input int row, input int col);
    return 8'(row * COLS + col);
  endfunction

  assign w_occ       = |ram_Q;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_r     <= '0;
      r_x     <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_y     <= w_y_n;
      r_r     <= w_r_n;
      r_x     <= w_x_n;
      r_full  <= w_full_n;
    end
  end

  // Handshake: start is sampled only in IDLE; busy stays high from that edge
  // through the single-cycle done pulse, and start is ignored while busy.
  always_comb begin
    w_state_n = r_state;
    w_y_n     = r_y;
    w_r_n     = r_r;
    w_x_n     = r_x;
    w_full_n  = r_full;
    ram_addr  = 8'd0;
    ram_data  = 6'd0;
    ram_wren  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_y_n     = Y_BOT;
          w_x_n     = '0;
          w_full_n  = 1'b1;
          w_state_n = SCAN;
        end
      end
      SCAN: begin
        if (r_x != X_END) ram_addr = cell_addr(int'(r_y), int'(r_x));
        // Read data lags the address by one cycle, so x=0 carries no data yet.
        if (r_x != '0) w_full_n = r_full & w_occ;
        if (r_x == X_END) begin
          w_x_n    = '0;
          w_full_n = 1'b1;
          if (r_full && w_occ) begin
            w_r_n     = r_y;
            w_state_n = (r_y == '0) ? CLR_TOP : COPY_RD;
          end else if (r_y == '0) begin
            w_state_n = DONE;
          end else begin
            w_y_n = r_y - 1'b1;
          end
        end else begin
          w_x_n = r_x + 1'b1;
        end
      end
      COPY_RD: begin
        ram_addr  = cell_addr(int'(r_r) - 1, int'(r_x));
        w_state_n = COPY_WR;
      end
      COPY_WR: begin
        ram_addr  = cell_addr(int'(r_r), int'(r_x));
        ram_data  = ram_Q;
        ram_wren  = 1'b1;
        w_state_n = COPY_RD;
        if (r_x == X_LAST) begin
          w_x_n = '0;
          if (r_r == YW'(1)) w_state_n = CLR_TOP;
          else               w_r_n     = r_r - 1'b1;
        end else begin
          w_x_n = r_x + 1'b1;
        end
      end
      CLR_TOP: begin
        ram_addr = cell_addr(0, int'(r_x));
        ram_wren = 1'b1;
        if (r_x == X_LAST) begin
          // Same y is rescanned so a row that just dropped into place is caught.
          w_x_n     = '0;
          w_full_n  = 1'b1;
          w_state_n = SCAN;
        end else begin
          w_x_n = r_x + 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        w_state_n = IDLE;
      end
      default: begin
        busy      = 1'b0;
        w_state_n = IDLE;
      end
    endcase
  end

`ifdef LINE_CLEAR_COUNT_EN
  logic [2:0] r_lines;
  logic       w_lines_clr;
  logic       w_lines_inc;

  always_comb begin
    w_lines_clr = (r_state == IDLE) && start;
    w_lines_inc = (r_state == SCAN) && (r_x == X_END) && r_full && w_occ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_lines <= 3'd0;
    else if (w_lines_clr)                     r_lines <= 3'd0;
    else if (w_lines_inc && r_lines != 3'd7)  r_lines <= r_lines + 3'd1;
  end

  assign lines_cleared = r_lines;
`else
  assign lines_cleared = 3'd0;
`endif

endmodule

// File: tb/tb_line_clear.sv
// Bench for line_clear: behavioural board RAM, gravity-compaction reference model, scenario tasks.
module tb_line_clear;

  localparam int COLS = 10;
  localparam int ROWS = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] ram_Q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic [2:0] lines_cleared;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] mem[256];
  logic [5:0] init_img[256];
  logic [5:0] exp_img[256];
  logic       ld_req = 1'b0;

  line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .ram_Q(ram_Q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .o_dbg_state(dbg_state)
  );

  // clock / board RAM (one-cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= mem[ram_addr];
  end

  // reference model: full rows vanish, the rest fall to the bottom in order
  task automatic model_pass(output int k, output int cyc);
    int dst;
    bit full;
    k = 0; cyc = 0; dst = ROWS - 1;
    for (int i = 0; i < 256; i++) exp_img[i] = 6'd0;
    for (int y = ROWS - 1; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < COLS; x++) if (init_img[y*COLS+x] == 6'd0) full = 1'b0;
      if (full) begin
        cyc += 2 * COLS * (y + k) + COLS;
        k++;
      end else begin
        for (int x = 0; x < COLS; x++) exp_img[dst*COLS+x] = init_img[y*COLS+x];
        dst--;
      end
    end
    cyc += (ROWS + k) * (COLS + 1) + 1;
  endtask

  function automatic logic [2:0] exp_lines(input int k);
`ifdef LINE_CLEAR_COUNT_EN
    return (k > 7) ? 3'd7 : 3'(k);
`else
    return 3'd0;
`endif
  endfunction

  function automatic logic [6*COLS-1:0] mem_row(input int y);
    logic [6*COLS-1:0] r;
    for (int x = 0; x < COLS; x++) r[6*x +: 6] = mem[y*COLS+x];
    return r;
  endfunction

  function automatic logic [6*COLS-1:0] exp_row(input int y);
    logic [6*COLS-1:0] r;
    for (int x = 0; x < COLS; x++) r[6*x +: 6] = exp_img[y*COLS+x];
    return r;
  endfunction

  function automatic logic [6*COLS-1:0] init_row(input int y);
    logic [6*COLS-1:0] r;
    for (int x = 0; x < COLS; x++) r[6*x +: 6] = init_img[y*COLS+x];
    return r;
  endfunction

  // driver tasks
  task automatic clear_img();
    for (int i = 0; i < 256; i++) init_img[i] = 6'd0;
  endtask

  task automatic fill_full_row(input int y);
    for (int x = 0; x < COLS; x++) init_img[y*COLS+x] = 6'($urandom_range(1, 63));
  endtask

  task automatic fill_partial_row(input int y);
    for (int x = 0; x < COLS; x++)
      init_img[y*COLS+x] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
    init_img[y*COLS + $urandom_range(0, COLS - 1)] = 6'd0;
  endtask

  task automatic load_board();
    @(negedge clk); ld_req = 1'b1;
    @(negedge clk); ld_req = 1'b0;
  endtask

  task automatic run_pass(input int limit, input bit poke_start, output int done_at,
                          output int n_done, output bit wren_seen, output bit lines_nz);
    int cnt;
    int tail;
    done_at = -1; n_done = 0; wren_seen = 1'b0; lines_nz = 1'b0; tail = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 1;
    while (cnt <= limit && tail < 6) begin
      if (poke_start) start = (cnt == 7 || cnt == 8);
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cnt;
      end
      if (ram_wren) wren_seen = 1'b1;
      if (lines_cleared != 3'd0) lines_nz = 1'b1;
      if (done_at >= 0) tail++;
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    #3;
    n_vec++; if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)          begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (ram_wren !== 1'b0)      begin n_err++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    n_vec++; if (ram_addr !== 8'd0)      begin n_err++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    n_vec++; if (ram_data !== 6'd0)      begin n_err++; $display("FAIL reset_data got %h want 0", ram_data); end
    n_vec++; if (lines_cleared !== 3'd0) begin n_err++; $display("FAIL reset_lines got %0d want 0", lines_cleared); end
    n_vec++; if (dbg_state !== 3'd0)     begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_empty_board();
    int k, cyc, done_at, n_done;
    bit wren_seen, lines_nz;
    clear_img();
    load_board();
    model_pass(k, cyc);
    run_pass(cyc + 20, 1'b0, done_at, n_done, wren_seen, lines_nz);
    n_vec++; if (done_at !== 265)  begin n_err++; $display("FAIL empty_done_cycle got %0d want 265", done_at); end
    n_vec++; if (n_done !== 1)     begin n_err++; $display("FAIL empty_done_pulses got %0d want 1", n_done); end
    n_vec++; if (wren_seen !== 1'b0) begin n_err++; $display("FAIL empty_wren got %b want 0", wren_seen); end
    n_vec++; if (lines_cleared !== 3'd0) begin n_err++; $display("FAIL empty_lines got %0d want 0", lines_cleared); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL empty_busy_after got %b want 0", busy); end
    n_vec++; if (ram_addr !== 8'd0 || ram_data !== 6'd0)
      begin n_err++; $display("FAIL idle_addr_data got %0d/%h want 0/0", ram_addr, ram_data); end
  endtask

  task automatic test_single_line();
    int k, cyc, done_at, n_done, bad;
    bit wren_seen, lines_nz;
    clear_img();
    fill_full_row(ROWS - 1);
    init_img[22*COLS+3] = 6'h0C;
    load_board();
    model_pass(k, cyc);
    run_pass(cyc + 20, 1'b0, done_at, n_done, wren_seen, lines_nz);
    n_vec++; if (done_at !== cyc) begin n_err++; $display("FAIL single_done_cycle got %0d want %0d", done_at, cyc); end
    n_vec++; if (n_done !== 1)    begin n_err++; $display("FAIL single_done_pulses got %0d want 1", n_done); end
    n_vec++; if (lines_cleared !== exp_lines(1))
      begin n_err++; $display("FAIL single_lines got %0d want %0d", lines_cleared, exp_lines(1)); end
    bad = 0;
    for (int x = 0; x < COLS; x++) if (mem[23*COLS+x] !== ((x == 3) ? 6'h0C : 6'd0)) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL single_row23 got %h bad_cells %0d want only x3=0c", mem_row(23), bad); end
    n_vec++; if (mem_row(0) !== '0) begin n_err++; $display("FAIL single_row0 got %h want 0", mem_row(0)); end
    for (int y = 0; y < ROWS; y++) begin
      n_vec++;
      if (mem_row(y) !== exp_row(y)) begin n_err++; $display("FAIL single_board row %0d got %h want %h", y, mem_row(y), exp_row(y)); end
    end
  endtask

  task automatic test_four_stack();
    int k, cyc, done_at, n_done;
    bit wren_seen, lines_nz, exp_nz;
`ifdef LINE_CLEAR_COUNT_EN
    exp_nz = 1'b1;
`else
    exp_nz = 1'b0;
`endif
    clear_img();
    for (int y = 20; y < 24; y++) fill_full_row(y);
    for (int y = 16; y < 20; y++)
      for (int x = 0; x < COLS; x++)
        init_img[y*COLS+x] = (x == y - 16 || x == y - 12) ? 6'd0 : 6'((y * 11 + x * 5) % 63 + 1);
    load_board();
    model_pass(k, cyc);
    run_pass(cyc + 20, 1'b0, done_at, n_done, wren_seen, lines_nz);
    n_vec++; if (done_at !== cyc) begin n_err++; $display("FAIL stack_done_cycle got %0d want %0d", done_at, cyc); end
    n_vec++; if (lines_cleared !== exp_lines(4))
      begin n_err++; $display("FAIL stack_lines got %0d want %0d", lines_cleared, exp_lines(4)); end
    n_vec++; if (lines_nz !== exp_nz) begin n_err++; $display("FAIL stack_lines_during got %b want %b", lines_nz, exp_nz); end
    for (int y = 20; y < 24; y++) begin
      n_vec++;
      if (mem_row(y) !== init_row(y - 4)) begin n_err++; $display("FAIL stack_row %0d got %h want %h", y, mem_row(y), init_row(y - 4)); end
    end
    for (int y = 0; y < 4; y++) begin
      n_vec++;
      if (mem_row(y) !== '0) begin n_err++; $display("FAIL stack_top row %0d got %h want 0", y, mem_row(y)); end
    end
    for (int y = 0; y < ROWS; y++) begin
      n_vec++;
      if (mem_row(y) !== exp_row(y)) begin n_err++; $display("FAIL stack_board row %0d got %h want %h", y, mem_row(y), exp_row(y)); end
    end
  endtask

  task automatic test_start_while_busy();
    int k, cyc, done_at, n_done;
    bit wren_seen, lines_nz;
    clear_img();
    fill_full_row(ROWS - 1);
    for (int y = 10; y < ROWS - 1; y++) fill_partial_row(y);
    load_board();
    model_pass(k, cyc);
    run_pass(cyc + 20, 1'b1, done_at, n_done, wren_seen, lines_nz);
    n_vec++; if (done_at !== cyc) begin n_err++; $display("FAIL busy_start_cycle got %0d want %0d", done_at, cyc); end
    n_vec++; if (n_done !== 1)    begin n_err++; $display("FAIL busy_start_pulses got %0d want 1", n_done); end
    for (int y = 0; y < ROWS; y++) begin
      n_vec++;
      if (mem_row(y) !== exp_row(y)) begin n_err++; $display("FAIL busy_start_board row %0d got %h want %h", y, mem_row(y), exp_row(y)); end
    end
  endtask

  task automatic test_reset_mid_copy();
    int cnt;
    clear_img();
    fill_full_row(ROWS - 1);
    fill_partial_row(ROWS - 2);
    load_board();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!ram_wren && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++; if (ram_wren !== 1'b1) begin n_err++; $display("FAIL midreset_reach_copy got wren %b want 1", ram_wren); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_vec++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL midreset_wren got %b want 0", ram_wren); end
    n_vec++; if (ram_addr !== 8'd0) begin n_err++; $display("FAIL midreset_addr got %0d want 0", ram_addr); end
    n_vec++; if (lines_cleared !== 3'd0) begin n_err++; $display("FAIL midreset_lines got %0d want 0", lines_cleared); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_idle got busy %b want 0", busy); end
  endtask

  task automatic test_random();
    int k, cyc, done_at, n_done;
    bit wren_seen, lines_nz;
    for (int it = 0; it < 4; it++) begin
      clear_img();
      for (int y = 0; y < ROWS; y++) begin
        if ($urandom_range(0, 9) < 3) fill_full_row(y);
        else if ($urandom_range(0, 3) != 0) fill_partial_row(y);
      end
      load_board();
      model_pass(k, cyc);
      run_pass(cyc + 20, 1'b0, done_at, n_done, wren_seen, lines_nz);
      n_vec++; if (done_at !== cyc) begin n_err++; $display("FAIL rand%0d_cycle got %0d want %0d", it, done_at, cyc); end
      n_vec++; if (n_done !== 1)    begin n_err++; $display("FAIL rand%0d_pulses got %0d want 1", it, n_done); end
      n_vec++; if (lines_cleared !== exp_lines(k))
        begin n_err++; $display("FAIL rand%0d_lines got %0d want %0d", it, lines_cleared, exp_lines(k)); end
      for (int y = 0; y < ROWS; y++) begin
        n_vec++;
        if (mem_row(y) !== exp_row(y)) begin n_err++; $display("FAIL rand%0d_board row %0d got %h want %h", it, y, mem_row(y), exp_row(y)); end
      end
    end
  endtask

  task automatic test_saturation();
    int k, cyc, done_at, n_done;
    bit wren_seen, lines_nz;
    clear_img();
    for (int y = 15; y < ROWS; y++) fill_full_row(y);
    fill_full_row(0);
    for (int y = 5; y < 15; y++) fill_partial_row(y);
    load_board();
    model_pass(k, cyc);
    run_pass(cyc + 20, 1'b0, done_at, n_done, wren_seen, lines_nz);
    n_vec++; if (done_at !== cyc) begin n_err++; $display("FAIL sat_cycle got %0d want %0d", done_at, cyc); end
    n_vec++; if (lines_cleared !== exp_lines(10))
      begin n_err++; $display("FAIL sat_lines got %0d want %0d", lines_cleared, exp_lines(10)); end
    for (int y = 0; y < ROWS; y++) begin
      n_vec++;
      if (mem_row(y) !== exp_row(y)) begin n_err++; $display("FAIL sat_board row %0d got %h want %h", y, mem_row(y), exp_row(y)); end
    end
    repeat (3) @(negedge clk);
    n_vec++; if (lines_cleared !== exp_lines(10))
      begin n_err++; $display("FAIL sat_lines_hold got %0d want %0d", lines_cleared, exp_lines(10)); end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_single_line();
    test_four_stack();
    test_start_while_busy();
    test_reset_mid_copy();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning board width in cells.
REQ-002 SHALL have parameter ROWS, default 24, meaning board height in cells, rows 0-3 hidden and rows 4-23 visible.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a level-sampled request to begin a clear pass.
REQ-006 SHALL have port ram_Q, input, 6 bits, the board RAM read data, valid one cycle after ram_addr is presented.
REQ-007 SHALL have port ram_addr, output, 8 bits, the board RAM address, equal to y*COLS+x.
REQ-008 SHALL have port ram_data, output, 6 bits, the board RAM write data.
REQ-009 SHALL have port ram_wren, output, 1 bit, the board RAM write enable.
REQ-010 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a pass.
REQ-012 SHALL have port lines_cleared, output, 3 bits, the number of rows removed in the last pass, saturating at 7.

Function
REQ-013 SHALL treat colour 6'b000000 as an empty cell and any other colour as an occupied cell.
REQ-014 SHALL implement FSM states IDLE, SCAN, COPY_RD, COPY_WR, CLR_TOP and DONE.
REQ-015 SHALL, in IDLE with start=1 at an edge, zero lines_cleared, set row y=ROWS-1 and enter SCAN.
REQ-016 SHALL, in SCAN, issue addresses x=0..COLS-1 of row y on consecutive cycles and AND the occupied test of ram_Q one cycle later, taking exactly COLS+1 cycles per row with no early exit.
REQ-017 SHALL, at the end of a SCAN of a row that is not full, enter DONE if y=0, otherwise decrement y and rescan.
REQ-018 SHALL, at the end of a SCAN of a full row, increment lines_cleared (saturating), set r=y and x=0, and enter COPY_RD.
REQ-019 SHALL, in COPY_RD, present address (r-1)*COLS+x with ram_wren=0.
REQ-020 SHALL, in COPY_WR, present address r*COLS+x with ram_data=ram_Q and ram_wren=1, then advance x.
REQ-021 SHALL, after x=COLS-1, decrement r and return to COPY_RD, or enter CLR_TOP once r reaches 1.
REQ-022 SHALL, in CLR_TOP, write 0 to addresses 0..COLS-1 on consecutive cycles, then rescan the same y without decrementing it, so that stacked full rows are caught.
REQ-023 SHALL, in DONE, assert done=1 for one cycle and then enter IDLE; lines_cleared holds until the next start.
REQ-024 SHALL ignore start when busy=1.
REQ-025 SHALL drive ram_wren=0 in IDLE, SCAN, COPY_RD and DONE.
REQ-026 SHALL drive ram_addr=0 and ram_data=0 in IDLE.
REQ-027 SHALL treat a full row 0 as a normal full row: no copy occurs, CLR_TOP runs directly, and row 0 is rescanned.

Reset
REQ-028 SHALL, on reset=1, immediately force IDLE with busy=0, done=0, ram_wren=0, ram_addr=0, ram_data=0 and lines_cleared=0, regardless of clk.
REQ-029 SHALL, on reset mid-pass, abandon the pass with RAM left partially shifted; no recovery is attempted.
REQ-030 SHALL leave the first edge after reset deasserts as an ordinary IDLE cycle.

Configuration
REQ-031 SHALL use the macro LINE_CLEAR_COUNT_EN: when defined, lines_cleared counts as specified; when undefined, lines_cleared is constant 0, the counter is absent, and all other behaviour is identical.

Verification
REQ-032 SHALL cover an empty board with start at edge N: SCAN occupies cycles N+1..N+264, done is high at N+265, lines_cleared=0, and ram_wren is never 1.
REQ-033 SHALL cover row 23 full and row 22 holding only x=3 at 6'h0C: after done, row 23 holds only x=3=6'h0C, row 0 is all zero, and lines_cleared=1.
REQ-034 SHALL cover rows 20-23 full and rows 16-19 with distinct patterns: after done, rows 20-23 equal the original rows 16-19, rows 0-3 are zero, and lines_cleared=4.
REQ-035 SHALL cover reset=1 asserted during COPY_WR: busy, ram_wren and ram_addr reach 0 before the next clk edge.
REQ-036 SHALL cover start pulsed while busy=1: the pass is unaffected, exactly one done pulse occurs, and the cycle count is unchanged.
REQ-037 SHALL cover LINE_CLEAR_COUNT_EN undefined with the REQ-034 stimulus: RAM results are identical and lines_cleared=0 throughout.
